mcp3202_responder: RTL and testbench

Synthesizable SPI responder that emulates an MCP3202 12-bit ADC: the far end of the ADC SPI link driven by the audio-input master.
- Decodes the start/SGL/ODD/MSBF command and returns the null bit plus a 12-bit conversion built from parallel sample inputs.
- Used as a loopback/self-test target on the board and as a bench model for the ADC master.
- All SPI pins are oversampled in the single system clock domain.

---
 rtl/mcp3202_pkg.sv | 42 ++++
 rtl/spi_pin_sync.sv | 47 ++++
 rtl/mcp3202_responder.sv | 176 +++++++++++++++++
 tb/tb_mcp3202_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mcp3202_pkg.sv
// mcp3202_pkg: shared types and constants for the MCP3202 responder.
//   state_t       - responder frame FSM states
//   cfg_t         - command fields captured after the start bit {sgl, odd, msbf}
//   select_value  - picks or clamps the conversion result from the two samples
package mcp3202_pkg;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned CFG_BITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CFG,
    NULL_WAIT,
    MSB_OUT,
    LSB_OUT,
    TRAIL
  } state_t;

  typedef struct packed {
    logic sgl;
    logic odd;
    logic msbf;
  } cfg_t;

  // Single-ended returns the raw channel; differential subtracts through a
  // 13-bit intermediate and clamps negative results to zero via the sign bit.
  function automatic logic [DATA_W-1:0] select_value(
    input cfg_t              cfg,
    input logic [DATA_W-1:0] ch0,
    input logic [DATA_W-1:0] ch1
  );
    logic [DATA_W:0] diff;
    if (cfg.sgl) begin
      select_value = cfg.odd ? ch1 : ch0;
    end else begin
      diff = cfg.odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
      select_value = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings the SPI pins into the clk domain.
//   clk, reset_n          - system clock, async active-low reset
//   spi_cs/sck/mosi       - raw pins
//   cs_s, mosi_s          - synchronised chip select / data
//   sck_rise, sck_fall    - one-clk pulses on synchronised sck edges
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall
);

  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_prev;

  // cs resets to the deselected level so reset release never looks like a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sr    <= '1;
      sck_sr   <= '0;
      mosi_sr  <= '0;
      sck_prev <= 1'b0;
    end else begin
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], spi_cs};
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sck_prev <= sck_sr[SYNC_STAGES-1];
    end
  end

  always_comb begin
    cs_s     = cs_sr[SYNC_STAGES-1];
    mosi_s   = mosi_sr[SYNC_STAGES-1];
    sck_rise = sck_sr[SYNC_STAGES-1] & ~sck_prev;
    sck_fall = ~sck_sr[SYNC_STAGES-1] & sck_prev;
  end

endmodule

// File: rtl/mcp3202_responder.sv
// mcp3202_responder: SPI slave emulating an MCP3202 12-bit ADC.
//   clk, reset_n        - system clock (>= 8x sck), async active-low reset
//   spi_cs              - frame active while low
//   spi_sck, spi_mosi   - master clock (idle low) and command bits
//   spi_miso, miso_oe   - returned data and pad output enable
//   ch0_data, ch1_data  - parallel samples
//   conv_valid          - one-clk pulse when a conversion is latched
//   conv_cfg            - {SGL,ODD} of the latched conversion
//   conv_value          - conversion value for the current frame
//   frame_err           - one-clk pulse when cs rises before B0 is shifted out
module mcp3202_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              conv_valid,
  output logic [1:0]        conv_cfg,
  output logic [DATA_W-1:0] conv_value,
  output logic              frame_err
);
  import mcp3202_pkg::*;

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(CFG_BITS);

  logic cs_s, mosi_s, sck_rise, sck_fall;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .spi_cs  (spi_cs),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .cs_s    (cs_s),
    .mosi_s  (mosi_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall)
  );

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              miso_q, miso_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [1:0]        ccfg_q, ccfg_d;
  logic [DATA_W-1:0] value_q, value_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      bitcnt_q <= '0;
      idx_q    <= '0;
      miso_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ccfg_q   <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      miso_q   <= miso_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ccfg_q   <= ccfg_d;
      value_q  <= value_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    miso_d   = miso_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    ccfg_d   = ccfg_q;
    value_d  = value_q;

    if (cs_s) begin
      // Deselect wins over any coincident sck edge. Leaving MSB_OUT always
      // means B0 has not been driven yet, since driving B0 exits that state.
      state_d  = IDLE;
      miso_d   = 1'b0;
      bitcnt_d = '0;
      idx_d    = '0;
      err_d    = (state_q == CFG) || (state_q == NULL_WAIT) || (state_q == MSB_OUT);
    end else begin
      case (state_q)
        IDLE: begin
          miso_d  = 1'b0;
          state_d = WAIT_START;
        end
        WAIT_START: begin
          if (sck_rise && mosi_s) begin
            state_d  = CFG;
            bitcnt_d = '0;
          end
        end
        CFG: begin
          if (sck_rise) begin
            if (bitcnt_q == CNT_W'(0))      cfg_d.sgl  = mosi_s;
            else if (bitcnt_q == CNT_W'(1)) cfg_d.odd  = mosi_s;
            else                            cfg_d.msbf = mosi_s;
            if (bitcnt_q == CNT_W'(CFG_BITS - 1)) state_d = NULL_WAIT;
            else bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
        NULL_WAIT: begin
          if (sck_fall) begin
            value_d = select_value(cfg_q, ch0_data, ch1_data);
            ccfg_d  = {cfg_q.sgl, cfg_q.odd};
            valid_d = 1'b1;
            miso_d  = 1'b0;
            idx_d   = IDX_W'(DATA_W - 1);
            state_d = MSB_OUT;
          end
        end
        MSB_OUT: begin
          if (sck_fall) begin
            miso_d = value_q[idx_q];
            if (idx_q == '0) begin
              if (cfg_q.msbf) begin
                state_d = TRAIL;
              end else begin
                state_d = LSB_OUT;
                idx_d   = IDX_W'(1);
              end
            end else begin
              idx_d = idx_q - IDX_W'(1);
            end
          end
        end
        LSB_OUT: begin
          if (sck_fall) begin
            miso_d = value_q[idx_q];
            if (idx_q == IDX_W'(DATA_W - 1)) state_d = TRAIL;
            else idx_d = idx_q + IDX_W'(1);
          end
        end
        TRAIL: begin
          if (sck_fall) miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    miso_oe    = (state_q == MSB_OUT) || (state_q == LSB_OUT) || (state_q == TRAIL);
    spi_miso   = miso_oe & miso_q;
    conv_valid = valid_q;
    conv_cfg   = ccfg_q;
    conv_value = value_q;
    frame_err  = err_q;
  end

endmodule

// File: tb/tb_mcp3202_responder.sv
// tb_mcp3202_responder: directed frames with a scoreboard. The driver pushes
// expected miso bits, conversions and frame errors; monitors pop and compare.
module tb_mcp3202_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_cs, spi_sck, spi_mosi;
  logic        spi_miso, miso_oe;
  logic [11:0] ch0_data, ch1_data;
  logic        conv_valid;
  logic [1:0]  conv_cfg;
  logic [11:0] conv_value;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  cfg;
    logic [11:0] val;
  } conv_t;

  conv_t      conv_q[$];
  logic [1:0] bit_q[$];
  bit         err_q[$];

  always #5 clk = ~clk;

  mcp3202_responder #(
    .SYNC_STAGES(2),
    .DATA_W(12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .miso_oe   (miso_oe),
    .ch0_data  (ch0_data),
    .ch1_data  (ch1_data),
    .conv_valid(conv_valid),
    .conv_cfg  (conv_cfg),
    .conv_value(conv_value),
    .frame_err (frame_err)
  );

  // Conversion and frame-error monitor, sampled away from the active edge.
  conv_t conv_exp;
  always @(negedge clk) begin
    if (reset_n) begin
      if (conv_valid) begin
        checks++;
        if (conv_q.size() == 0) begin
          errors++;
          $display("FAIL conv_unexpected: got cfg=%b val=%h, none expected", conv_cfg, conv_value);
        end else begin
          conv_exp = conv_q.pop_front();
          if ({conv_cfg, conv_value} !== {conv_exp.cfg, conv_exp.val}) begin
            errors++;
            $display("FAIL conv: got cfg=%b val=%h, expected cfg=%b val=%h",
                     conv_cfg, conv_value, conv_exp.cfg, conv_exp.val);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL frame_err_unexpected: got 1, expected 0");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  // Master-side sampling of {miso_oe, spi_miso} on each sck rise.
  logic [1:0] bit_exp;
  always @(posedge spi_sck) begin
    checks++;
    if (bit_q.size() == 0) begin
      errors++;
      $display("FAIL bit_underflow: got oe/miso=%b%b, nothing expected", miso_oe, spi_miso);
    end else begin
      bit_exp = bit_q.pop_front();
      if ({miso_oe, spi_miso} !== bit_exp) begin
        errors++;
        $display("FAIL miso_bit: got oe/miso=%b%b, expected %b", miso_oe, spi_miso, bit_exp);
      end
    end
  end

  function automatic logic exp_bit(input logic [11:0] v, input bit msbf, input int j);
    if (j == 0) return 1'b0;
    if (j <= 12) return v[12-j];
    if (!msbf && j <= 23) return v[j-12];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic m, input logic [1:0] e);
    spi_mosi = m;
    repeat (8) @(negedge clk);
    bit_q.push_back(e);
    spi_sck = 1'b1;
    repeat (8) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic run_frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                           input logic [11:0] ev, input int n_data, input int chg_at,
                           input logic [11:0] chg_val, input bit abort_err, input bit rst_end);
    conv_q.push_back('{cfg: {sgl, odd}, val: ev});
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < lead; i++) sck_cycle(1'b0, 2'b00);
    sck_cycle(1'b1, 2'b00);
    sck_cycle(sgl, 2'b00);
    sck_cycle(odd, 2'b00);
    sck_cycle(msbf, 2'b00);
    for (int j = 0; j < n_data; j++) begin
      if (j == chg_at) ch0_data = chg_val;
      sck_cycle(1'b0, {1'b1, exp_bit(ev, msbf, j)});
    end
    if (rst_end) begin
      repeat (2) @(negedge clk);
      check("oe_before_reset", {31'd0, miso_oe}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check("outputs_in_reset",
               {15'd0, spi_miso, miso_oe, conv_valid, conv_cfg, conv_value, frame_err}, 32'd0);
      spi_cs = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      if (abort_err) err_q.push_back(1'b1);
      spi_cs = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("oe_after_cs", {30'd0, miso_oe, spi_miso}, 32'd0);
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    spi_cs   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    ch0_data = 12'hA5C;
    ch1_data = 12'h123;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs",
          {15'd0, spi_miso, miso_oe, conv_valid, conv_cfg, conv_value, frame_err}, 32'd0);

    // Single-ended ch0, MSB first.
    run_frame(0, 1, 0, 1, 12'hA5C, 15, -1, 12'h000, 0, 0);
    // Single-ended ch1, LSB tail.
    run_frame(0, 1, 1, 0, 12'h123, 26, -1, 12'h000, 0, 0);
    // Differential, positive and clamped.
    ch0_data = 12'h300; ch1_data = 12'h100;
    run_frame(0, 0, 0, 1, 12'h200, 15, -1, 12'h000, 0, 0);
    ch0_data = 12'h100; ch1_data = 12'h200;
    run_frame(0, 0, 0, 1, 12'h000, 15, -1, 12'h000, 0, 0);
    run_frame(0, 0, 1, 1, 12'h100, 15, -1, 12'h000, 0, 0);
    // Leading zeros before start bit.
    ch0_data = 12'hA5C; ch1_data = 12'h123;
    run_frame(3, 1, 0, 1, 12'hA5C, 15, -1, 12'h000, 0, 0);
    // Early deselect, then a clean frame.
    run_frame(0, 1, 0, 1, 12'hA5C, 5, -1, 12'h000, 1, 0);
    run_frame(0, 1, 0, 1, 12'hA5C, 15, -1, 12'h000, 0, 0);
    // Sample change after latch has no effect.
    run_frame(0, 1, 0, 1, 12'hA5C, 15, 4, 12'hFFF, 0, 0);
    // Reset mid-frame.
    ch0_data = 12'hA5C;
    run_frame(0, 1, 0, 1, 12'hA5C, 5, -1, 12'h000, 0, 1);

    repeat (10) @(negedge clk);
    check("conv_q_drained", conv_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);
    check("bit_q_drained", bit_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
